// File: rtl/uart_rx_led_monitor.sv
// uart_rx_led_monitor: 8N1 receiver for an LED-state stream.
// Flags stop-bit framing errors and breaks in the 4-bit LED sequence, and keeps a saturating error count.
module uart_rx_led_monitor #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       seq_err,
    output logic [3:0] led_echo,
    output logic [7:0] err_count
);
    localparam int CPB = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(CPB + 1);
    localparam logic [CW-1:0] LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t        state_q;
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q, data_q, errc_q;
    logic [3:0]    ref_q, echo_q;
    logic          valid_q, ferr_q, serr_q, armed_q;
    logic          rxs, cnt_end, good_d, bad_d, seq_d;

    assign rxs     = sync_q[1];
    assign cnt_end = cnt_q == LAST;
    assign good_d  = state_q == STOP && cnt_end && rxs;
    assign bad_d   = state_q == STOP && cnt_end && !rxs;
    assign seq_d   = good_d && armed_q && shift_q[3:0] != ref_q + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            errc_q  <= '0;
            ref_q   <= '0;
            echo_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            serr_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            valid_q <= good_d;
            ferr_q  <= bad_d;
            serr_q  <= seq_d;
            if ((bad_d || seq_d) && errc_q != 8'hFF)
                errc_q <= errc_q + 8'd1;
            // The reference follows every good byte, so a single dropped byte costs one seq_err.
            if (good_d) begin
                data_q  <= shift_q;
                echo_q  <= shift_q[3:0];
                ref_q   <= shift_q[3:0];
                armed_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (!rxs) state_q <= START;
                end
                START: begin
                    cnt_q <= cnt_q == HALF ? '0 : cnt_q + 1'b1;
                    idx_q <= '0;
                    if (cnt_q == HALF) state_q <= rxs ? IDLE : DATA;
                end
                DATA: begin
                    cnt_q <= cnt_end ? '0 : cnt_q + 1'b1;
                    if (cnt_end) begin
                        shift_q <= {rxs, shift_q[7:1]};
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'd7) state_q <= STOP;
                    end
                end
                STOP: begin
                    cnt_q <= cnt_end ? '0 : cnt_q + 1'b1;
                    if (cnt_end) state_q <= rxs ? IDLE : WAIT_HIGH;
                end
                WAIT_HIGH: if (rxs) state_q <= IDLE;
                default:   state_q <= IDLE;
            endcase
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign seq_err   = serr_q;
    assign led_echo  = echo_q;
    assign err_count = errc_q;
endmodule

// File: doc/uart_rx_led_monitor.md
UART_RX_LED_MONITOR -- requirements
Module: uart_rx_led_monitor

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate; CPB = CLK_FREQ/BAUD, integer division (434 at defaults).
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx  input  1  serial 8N1 line from the LED-state UART transmitter; idles high.
REQ-006 rx_data  output  8  last correctly framed byte.
REQ-007 rx_valid  output  1  one-cycle pulse; rx_data is new this cycle.
REQ-008 frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-009 seq_err  output  1  one-cycle pulse; received LED nibble is not previous+1 mod 16.
REQ-010 led_echo  output  4  rx_data[3:0] of last valid byte.
REQ-011 err_count  output  8  saturating count of frame_err plus seq_err events.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer whose flops reset to 1; all decoding uses the synchronized signal rxs.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP, WAIT_HIGH, plus a bit-period counter (0..CPB-1) and a 3-bit bit index.
REQ-014 IDLE: when rxs=0, go to START and clear the counter.
REQ-015 START: at counter = CPB/2-1, if rxs=0 go to DATA with counter cleared; if rxs=1 (glitch), go to IDLE with no output pulse.
REQ-016 DATA: sample rxs at counter = CPB-1 into bit[index], LSB first; after index 7, go to STOP.
REQ-017 STOP: at counter = CPB-1, sample rxs; if 1, load rx_data, pulse rx_valid on the next cycle, and go to IDLE.
REQ-018 STOP sample = 0: pulse frame_err, leave rx_data, led_echo, and the sequence reference unchanged, and go to WAIT_HIGH.
REQ-019 WAIT_HIGH: remain there until rxs=1, then go to IDLE; a held-low break produces exactly one frame_err.
REQ-020 Latency: rx_valid SHALL be high in clock 2 + CPB/2 + 9*CPB + 1 after the first clock edge that samples rx low (2 synchronizer cycles included).
REQ-021 On rx_valid, led_echo SHALL load rx_data[3:0] in the same cycle.
REQ-022 Sequence check SHALL be disarmed after reset; the first valid byte arms it without checking.
REQ-023 When armed, a valid byte whose nibble is not ref+1 mod 16 SHALL pulse seq_err in the same cycle as rx_valid; 15 -> 0 is legal.
REQ-024 ref SHALL update to the received nibble on every valid byte, including mismatches, so one dropped byte yields one seq_err.
REQ-025 rx_data[7:4] SHALL be ignored by the sequence check.
REQ-026 err_count SHALL increment by 1 on each frame_err or seq_err pulse and hold at 255; frame_err and seq_err are never high in the same cycle.
REQ-027 Back-to-back frames with no idle gap between the stop bit and the next start bit SHALL be received without loss.

Reset
REQ-028 reset SHALL immediately force FSM=IDLE, counters=0, synchronizer=1, rx_data=0, led_echo=0, rx_valid=frame_err=seq_err=0, err_count=0, and the sequence check disarmed.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no output pulse; after release, decoding SHALL resume at the next falling edge of rx.

Verification
REQ-030 Send 0x00..0x0F, then 0x00, at 115200 baud -> 17 rx_valid pulses, led_echo tracks each nibble, seq_err=0, err_count=0, wrap accepted.
REQ-031 Send 0x03 then 0x05 -> second rx_valid carries seq_err=1, err_count=1, led_echo=5; a following 0x06 gives no seq_err.
REQ-032 Send 0xA5 with a stop bit of 0, then 0xA6 -> frame_err pulse, err_count=1, rx_data stays at its prior value; 0xA6 is received as the first byte (no seq_err).
REQ-033 Drive a low glitch on rx of CPB/4 cycles -> no rx_valid, no frame_err, FSM back to IDLE.
REQ-034 Assert reset during bit 4 of a frame -> all outputs 0; the next complete frame 0x07 gives rx_valid with rx_data=0x07 and no seq_err.
REQ-035 Force 300 consecutive seq errors (alternate 0x00/0x00) -> err_count saturates at 255; check REQ-020 latency exactly on the first frame.
